acq_search_sched: RTL

- Job sequencer in front of the acquisition IP; runs in the core_clk domain.
- Firmware queues search jobs, each holding a PRN, a start Doppler, a Doppler step and a bin count.
- For each job the block arms a sample capture on the next epoch, then steps the correlator core through every Doppler bin, keeping the strongest peak.
- It emits one result per job through a valid/ready port.

---
 rtl/acq_search_sched.sv | 270 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/acq_search_sched.sv
// Acquisition search job sequencer.
// Queues firmware search jobs and, for each one, arms a capture on the next
// epoch, steps the correlator through every Doppler bin keeping the strongest
// peak, then presents one result on a valid/ready port.
//
// state        | meaning
// -------------+----------------------------------------------
// S_IDLE       | waiting for a queued job
// S_WAIT_EP    | job loaded, waiting for epoch to arm capture
// S_CAPTURE    | capture armed, waiting for cap_done
// S_SRCH_GO    | one-cycle correlator launch for current bin
// S_SRCH_WAIT  | waiting for srch_done on current bin
// S_NEXT       | fold bin into best result, advance Doppler
// S_REPORT     | result presented until res_ready
module acq_search_sched #(
   parameter int PRN_W  = 6,
   parameter int FREQ_W = 16,
   parameter int NBIN_W = 8,
   parameter int PEAK_W = 32,
   parameter int IDX_W  = 18,
   parameter int QDEPTH = 8,
   parameter int TMO_W  = 24
) (
   input  logic              core_clk,
   input  logic              rst,
   input  logic              job_wr,
   input  logic [PRN_W-1:0]  job_prn,
   input  logic [FREQ_W-1:0] job_freq,
   input  logic [FREQ_W-1:0] job_step,
   input  logic [NBIN_W-1:0] job_nbins,
   output logic              job_full,
   output logic              job_ovf,
   input  logic              abort,
   input  logic              epoch,
   output logic              cap_start,
   input  logic              cap_done,
   output logic              srch_start,
   output logic [PRN_W-1:0]  srch_prn,
   output logic [FREQ_W-1:0] srch_freq,
   input  logic              srch_done,
   input  logic [PEAK_W-1:0] srch_peak,
   input  logic [IDX_W-1:0]  srch_idx,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [PRN_W-1:0]  res_prn,
   output logic [FREQ_W-1:0] res_freq,
   output logic [PEAK_W-1:0] res_peak,
   output logic [IDX_W-1:0]  res_idx,
   output logic              res_tmo,
   output logic              busy
);
   localparam int AW = $clog2(QDEPTH);
   localparam int JW = PRN_W + 2 * FREQ_W + NBIN_W;
   localparam logic [AW:0]       DEPTH    = (AW + 1)'(QDEPTH);
   localparam logic [AW:0]       CNT_ONE  = (AW + 1)'(1);
   localparam logic [NBIN_W-1:0] BIN_ONE  = NBIN_W'(1);
   localparam logic [TMO_W-1:0]  TMO_ONE  = TMO_W'(1);

   typedef enum logic [2:0] {
      S_IDLE, S_WAIT_EP, S_CAPTURE, S_SRCH_GO, S_SRCH_WAIT, S_NEXT, S_REPORT
   } state_t;

   state_t state_q, state_d;

   logic [JW-1:0]     fifo_q [QDEPTH];
   logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
   logic [AW:0]       cnt_q, cnt_d;
   logic              full_q, ovf_q;
   logic              push, pop;

   logic [PRN_W-1:0]  pop_prn;
   logic [FREQ_W-1:0] pop_freq, pop_step;
   logic [NBIN_W-1:0] pop_nbins;

   logic [PRN_W-1:0]  prn_q;
   logic [FREQ_W-1:0] step_q, cur_freq_q, cur_freq_n;
   logic [NBIN_W-1:0] rem_q;
   logic [PEAK_W-1:0] best_peak_q, best_peak_n, bin_peak_q;
   logic [IDX_W-1:0]  best_idx_q, best_idx_n, bin_idx_q;
   logic [FREQ_W-1:0] best_freq_q, best_freq_n;
   logic [TMO_W-1:0]  tmo_q;
   logic              tmo_hit, tmo_evt, more, better, go_entry, rep_entry;
   logic [PRN_W-1:0]  srch_prn_q, res_prn_q;
   logic [FREQ_W-1:0] srch_freq_q, res_freq_q;
   logic [PEAK_W-1:0] res_peak_q;
   logic [IDX_W-1:0]  res_idx_q;
   logic              res_tmo_q;

   // A push while full is dropped even if a pop happens in the same cycle.
   assign push = job_wr && !abort && !full_q;
   assign pop  = (state_q == S_IDLE) && (cnt_q != '0) && !abort;
   assign {pop_prn, pop_freq, pop_step, pop_nbins} = fifo_q[rd_ptr_q];

   assign tmo_hit = &tmo_q;
   assign more    = (rem_q != BIN_ONE);
   assign better  = (bin_peak_q > best_peak_q);

   assign cur_freq_n  = (state_q == S_NEXT && more) ? cur_freq_q + step_q : cur_freq_q;
   assign best_peak_n = (state_q == S_NEXT && better) ? bin_peak_q : best_peak_q;
   assign best_idx_n  = (state_q == S_NEXT && better) ? bin_idx_q  : best_idx_q;
   assign best_freq_n = (state_q == S_NEXT && better) ? cur_freq_q : best_freq_q;

   assign go_entry  = (state_d == S_SRCH_GO) && (state_q != S_SRCH_GO);
   assign rep_entry = (state_d == S_REPORT) && (state_q != S_REPORT);

   // Occupancy count of the job FIFO.
   always_comb begin
      cnt_d = cnt_q;
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + CNT_ONE;
         2'b01:   cnt_d = cnt_q - CNT_ONE;
         default: cnt_d = cnt_q;
      endcase
      if (abort) cnt_d = '0;
   end

   // Job storage; contents need no reset since pointers define validity.
   always_ff @(posedge core_clk) begin
      if (push) fifo_q[wr_ptr_q] <= {job_prn, job_freq, job_step, job_nbins};
   end

   // FIFO pointers, registered full flag and sticky overflow.
   always_ff @(posedge core_clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         full_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else if (abort) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         full_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         cnt_q  <= cnt_d;
         full_q <= (cnt_d == DEPTH);
         if (job_wr && full_q) ovf_q <= 1'b1;
      end
   end

   // Next-state and strobe decode; abort overrides everything.
   always_comb begin
      state_d    = state_q;
      cap_start  = 1'b0;
      srch_start = 1'b0;
      tmo_evt    = 1'b0;
      case (state_q)
         S_IDLE:      if (pop) state_d = S_WAIT_EP;
         S_WAIT_EP: begin
            if (epoch) begin
               cap_start = 1'b1;
               state_d   = S_CAPTURE;
            end else if (tmo_hit) begin
               tmo_evt = 1'b1;
               state_d = S_REPORT;
            end
         end
         S_CAPTURE: begin
            if (cap_done) state_d = S_SRCH_GO;
            else if (tmo_hit) begin
               tmo_evt = 1'b1;
               state_d = S_REPORT;
            end
         end
         S_SRCH_GO: begin
            srch_start = 1'b1;
            state_d    = S_SRCH_WAIT;
         end
         S_SRCH_WAIT: begin
            if (srch_done) state_d = S_NEXT;
            else if (tmo_hit) begin
               tmo_evt = 1'b1;
               state_d = S_REPORT;
            end
         end
         S_NEXT:      state_d = more ? S_SRCH_GO : S_REPORT;
         S_REPORT:    if (res_ready) state_d = S_IDLE;
         default:     state_d = S_IDLE;
      endcase
      if (abort) begin
         state_d    = S_IDLE;
         cap_start  = 1'b0;
         srch_start = 1'b0;
         tmo_evt    = 1'b0;
      end
   end

   // State register and watchdog; the watchdog restarts on every state change.
   always_ff @(posedge core_clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         tmo_q   <= '0;
      end else begin
         state_q <= state_d;
         if (state_d != state_q) tmo_q <= '0;
         else if (state_q == S_WAIT_EP || state_q == S_CAPTURE || state_q == S_SRCH_WAIT)
            tmo_q <= tmo_q + TMO_ONE;
      end
   end

   // Job context, best-bin tracking, correlator command and result registers.
   always_ff @(posedge core_clk or posedge rst) begin
      if (rst) begin
         prn_q       <= '0;
         step_q      <= '0;
         cur_freq_q  <= '0;
         rem_q       <= '0;
         best_peak_q <= '0;
         best_idx_q  <= '0;
         best_freq_q <= '0;
         bin_peak_q  <= '0;
         bin_idx_q   <= '0;
         srch_prn_q  <= '0;
         srch_freq_q <= '0;
         res_prn_q   <= '0;
         res_freq_q  <= '0;
         res_peak_q  <= '0;
         res_idx_q   <= '0;
         res_tmo_q   <= 1'b0;
      end else begin
         if (pop) begin
            prn_q       <= pop_prn;
            step_q      <= pop_step;
            cur_freq_q  <= pop_freq;
            rem_q       <= (pop_nbins == '0) ? BIN_ONE : pop_nbins;
            best_peak_q <= '0;
            best_idx_q  <= '0;
            best_freq_q <= pop_freq;
         end else begin
            cur_freq_q  <= cur_freq_n;
            best_peak_q <= best_peak_n;
            best_idx_q  <= best_idx_n;
            best_freq_q <= best_freq_n;
            if (state_q == S_NEXT) rem_q <= rem_q - BIN_ONE;
         end
         if (state_q == S_SRCH_WAIT && srch_done) begin
            bin_peak_q <= srch_peak;
            bin_idx_q  <= srch_idx;
         end
         if (go_entry) begin
            srch_prn_q  <= prn_q;
            srch_freq_q <= cur_freq_n;
         end
         if (rep_entry) begin
            res_prn_q  <= prn_q;
            res_freq_q <= best_freq_n;
            res_peak_q <= best_peak_n;
            res_idx_q  <= best_idx_n;
            res_tmo_q  <= tmo_evt;
         end
      end
   end

   assign job_full  = full_q;
   assign job_ovf   = ovf_q;
   assign srch_prn  = srch_prn_q;
   assign srch_freq = srch_freq_q;
   assign res_valid = (state_q == S_REPORT);
   assign res_prn   = res_prn_q;
   assign res_freq  = res_freq_q;
   assign res_peak  = res_peak_q;
   assign res_idx   = res_idx_q;
   assign res_tmo   = res_tmo_q;
   assign busy      = (state_q != S_IDLE);

endmodule
